data_collector: RTL and testbench
=================================

// Module: data_collector
// PURPOSE
//   Gathering end of the data_distributor path. Merges four DATA_W-bit source channels
//   onto one output stream through a fair round-robin arbiter.
//   Uses valid/ready handshakes on every channel and a single output holding register.
//   Tags each output word with its source channel (out_sel).
//   Counts completed output transfers for software and bench visibility.
// PARAMETERS
//   DATA_W   8    width of every data channel
//   COUNT_W  16   width of xfer_count; counter wraps modulo 2**COUNT_W
// PORTS
//   clk         in   1        single clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   enable      in   1        1 = grant new words; 0 = accept nothing new
//   in0_data    in   DATA_W   channel 0 data (in1_data..in3_data identical)
//   in_valid    in   4        bit i = channel i presents a word
//   in_ready    out  4        bit i = channel i word is accepted this cycle (one-hot or zero)
//   out_data    out  DATA_W   registered output word
//   out_sel     out  2        source channel of out_data
//   out_valid   out  1        out_data/out_sel hold a word
//   out_ready   in   1        downstream accepts the word this cycle
//   xfer_count  out  COUNT_W  number of completed output handshakes
// BEHAVIOUR
//   Reset (async, immediate, no clock needed):
//     - out_data=0, out_sel=0, out_valid=0, xfer_count=0, rr_ptr=0
//     - in_ready=0 while rst=1
//   FSM, 2 states:
//     - EMPTY (out_valid=0), FULL (out_valid=1)
//     - load_ok = !out_valid || out_ready
//   Arbiter (combinational):
//     - Search in_valid from rr_ptr upward, mod 4; first set bit is grant g
//     - in_ready[g] = enable && load_ok && any(in_valid); all other bits 0
//     - in_ready may depend combinationally on in_valid
//     - Sources must not make in_valid depend on in_ready
//   Accept (in_valid[g] && in_ready[g]) at edge:
//     - out_data <= in{g}_data, out_sel <= g, out_valid <= 1, rr_ptr <= (g+1) mod 4
//     - Latency: word appears on out_data one cycle after acceptance
//   Output handshake (out_valid && out_ready):
//     - xfer_count <= xfer_count+1, wrapping to 0 past all-ones
//     - If no accept the same cycle, out_valid <= 0 (FULL->EMPTY)
//     - Simultaneous drain + accept: register reloads and out_valid stays 1
//       (full throughput: one word per cycle)
//   Backpressure: FULL && !out_ready
//     - out_data, out_sel, out_valid held stable; in_ready=0
//   enable=0:
//     - No new grants; a word already in FULL still drains normally
//     - rr_ptr unchanged
//   No in_valid bits set: in_ready=0, rr_ptr unchanged
//   Fairness: with all channels continuously valid, each channel is granted exactly once
//   per 4 consecutive accepts
// TESTING
//   1. Assert rst with no clock edge -> all outputs 0 immediately; in_ready=0.
//   2. enable=1, in_valid=4'b0100, in2_data=8'hA5, out_ready=1 -> in_ready=4'b0100;
//      next cycle out_data=A5, out_sel=2, out_valid=1; xfer_count=1 one cycle later.
//   3. in_valid=4'b1111 held, out_ready=1, rr_ptr=0 -> out_sel sequence 0,1,2,3,0
//      on consecutive cycles; out_valid=1 throughout.
//   4. out_ready=0 while FULL with 8'hB5 -> out_data=B5 stable, in_ready=0, xfer_count frozen;
//      out_ready=1 -> drains and the next word loads the same cycle.
//   5. enable=0, in_valid=4'b1000, in3_data=8'h3C -> in_ready=0, out_valid stays 0 for 5 cycles;
//      enable=1 -> accepted, out_data=3C, out_sel=3.
//   6. Mid-FULL async rst pulse -> out_valid=0, xfer_count=0 before the next edge.
//      With COUNT_W=2, 5 transfers -> xfer_count=1 (wrap).

Source files
------------

// File: rtl/data_collector.sv
// rtl/data_collector.sv - four-channel round-robin collector onto a single registered output stream
module data_collector #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic [DATA_W-1:0]  in2_data,
    input  logic [DATA_W-1:0]  in3_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] xfer_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state;
    logic [1:0]        rr_ptr;
    logic [1:0]        grant_idx;
    logic              grant_found;
    logic [DATA_W-1:0] grant_data;
    logic              load_ok;
    logic              accept;
    logic              drain;

    assign out_valid = (state == FULL);
    assign load_ok   = !out_valid || out_ready;
    assign drain     = out_valid && out_ready;

    // Rotating priority: the channel just after the last winner is searched first.
    always_comb begin
        logic [1:0] cand;
        grant_idx   = rr_ptr;
        grant_found = 1'b0;
        cand        = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!grant_found && in_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_data = in0_data;
        case (grant_idx)
            2'd0: grant_data = in0_data;
            2'd1: grant_data = in1_data;
            2'd2: grant_data = in2_data;
            2'd3: grant_data = in3_data;
            default: grant_data = in0_data;
        endcase
    end

    // in_ready is held low throughout reset, independent of any clock edge.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && enable && load_ok && grant_found)
            in_ready[grant_idx] = 1'b1;
    end

    assign accept = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            rr_ptr     <= 2'd0;
            out_data   <= '0;
            out_sel    <= 2'd0;
            xfer_count <= '0;
        end else begin
            if (accept) begin
                out_data <= grant_data;
                out_sel  <= grant_idx;
                rr_ptr   <= grant_idx + 2'd1;
            end
            if (drain)
                xfer_count <= xfer_count + COUNT_W'(1);
            // A drain and a reload in the same cycle keep the register full.
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (drain && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_data_collector.sv
// tb/tb_data_collector.sv - scoreboard bench for data_collector
module tb_data_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  in0_data, in1_data, in2_data, in3_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_count;

    logic [3:0]  s_in_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_sel;
    logic        s_out_valid;
    logic [1:0]  s_xfer_count;

    int total = 0;
    int bad   = 0;

    logic [9:0]  sb[$];
    logic [1:0]  m_rr;
    logic        m_full;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    data_collector #(.DATA_W(8), .COUNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in0_data(in0_data), .in1_data(in1_data), .in2_data(in2_data), .in3_data(in3_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_count(xfer_count)
    );

    data_collector #(.DATA_W(8), .COUNT_W(2)) u_small (
        .clk(clk), .rst(rst), .enable(enable),
        .in0_data(in0_data), .in1_data(in1_data), .in2_data(in2_data), .in3_data(in3_data),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_valid(s_out_valid),
        .out_ready(out_ready), .xfer_count(s_xfer_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr    = 2'd0;
        m_full  = 1'b0;
        m_count = 16'd0;
        sb.delete();
    endtask

    // One clock: check handshakes at the falling edge, update the model, step past the rising edge.
    task automatic cycle();
        logic [1:0] g;
        logic [1:0] c;
        logic       found;
        logic [3:0] er;
        logic [7:0] d;
        logic [9:0] e;
        logic       drain;
        @(negedge clk);
        found = 1'b0;
        g     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            c = m_rr + 2'(k);
            if (!found && in_valid[c]) begin
                g     = c;
                found = 1'b1;
            end
        end
        er = (enable && (!m_full || out_ready) && found) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", {28'd0, in_ready}, {28'd0, er});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("xfer_count", {16'd0, xfer_count}, {16'd0, m_count});
        chk("small_count", {30'd0, s_xfer_count}, {30'd0, m_count[1:0]});
        drain = m_full && out_ready;
        if (drain) begin
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_word", {22'd0, out_sel, out_data}, {22'd0, e});
            end
            m_count = m_count + 16'd1;
        end
        case (g)
            2'd0: d = in0_data;
            2'd1: d = in1_data;
            2'd2: d = in2_data;
            default: d = in3_data;
        endcase
        if (er != 4'b0000) begin
            sb.push_back({g, d});
            m_rr   = g + 2'd1;
            m_full = 1'b1;
        end else if (drain) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq [5];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset with no clock edge yet
        rst = 1'b1; enable = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in0_data = 8'h10; in1_data = 8'h21; in2_data = 8'h32; in3_data = 8'h43;
        #1;
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_xfer_count", {16'd0, xfer_count}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        in_valid = 4'b0000;
        #2;
        rst = 1'b0;
        model_reset();

        // Single word from channel 2
        @(posedge clk); #1;
        in_valid = 4'b0100; in2_data = 8'hA5;
        #1;
        chk("t2_in_ready", {28'd0, in_ready}, 32'h4);
        cycle();
        chk("t2_out_data", {24'd0, out_data}, 32'hA5);
        chk("t2_out_sel", {30'd0, out_sel}, 32'd2);
        chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 4'b0000;
        cycle();
        chk("t2_xfer_count", {16'd0, xfer_count}, 32'd1);

        // Round-robin over all channels from pointer 0
        in_valid = 4'b1111; in2_data = 8'h32;
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_out_sel", {30'd0, out_sel}, {30'd0, seq[i]});
            chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
        end

        // Backpressure holds the register and blocks grants
        in_valid = 4'b0001; in0_data = 8'hB5;
        cycle();
        chk("t4_load", {24'd0, out_data}, 32'hB5);
        out_ready = 1'b0; in_valid = 4'b0010; in1_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_hold_data", {24'd0, out_data}, 32'hB5);
            chk("t4_hold_ready", {28'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("t4_reload_data", {24'd0, out_data}, 32'h11);
        chk("t4_reload_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 4'b0000;
        cycle();

        // Disabled: nothing granted until enable returns
        enable = 1'b0; in_valid = 4'b1000; in3_data = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_idle_valid", {31'd0, out_valid}, 32'd0);
        end
        enable = 1'b1;
        cycle();
        chk("t5_out_data", {24'd0, out_data}, 32'h3C);
        chk("t5_out_sel", {30'd0, out_sel}, 32'd3);
        in_valid = 4'b0000;
        cycle();

        // Asynchronous reset while full, then counter wrap
        in_valid = 4'b0001; in0_data = 8'h5A; out_ready = 1'b0;
        cycle();
        chk("t6_full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_count", {16'd0, xfer_count}, 32'd0);
        chk("t6_rst_ready", {28'd0, in_ready}, 32'd0);
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        in_valid = 4'b0000;
        cycle();
        chk("t6_count", {16'd0, xfer_count}, 32'd5);
        chk("t6_wrap", {30'd0, s_xfer_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
